cic_decimator: RTL and testbench

- Decimating CIC filter for the ADC/receive direction of the sigma-delta path.
- Takes a 1-bit sigma-delta bitstream at the modulator rate and produces signed OUT_WIDTH-bit PCM samples at 1/2^DECIM_LOG2 of that rate.
- Rate handshake matches the interpolating chain: clk_enable qualifies input samples; ce_out strobes output samples.
- Sits between the external modulator bitstream and downstream half-band decimation stages.

---
 rtl/cic_decimator_if.sv | 26 ++
 rtl/cic_decimator.sv | 98 +++++++++
 tb/tb_cic_decimator.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/cic_decimator_if.sv
// Sample-rate handshake bundle between the sigma-delta bitstream source and the CIC decimator.
// Handshake: clk_enable is a one-clk qualifier, not a valid/ready pair. There is no backpressure:
// a sample is consumed on every rising clk edge where clk_enable=1. ce_out is a one-clk strobe
// and output_data holds the new sample from that cycle until the next ce_out.
interface cic_decimator_if #(
    parameter int OUT_WIDTH = 16
);
    logic                        clk_enable;
    logic                        input_bit;
    logic signed [OUT_WIDTH-1:0] output_data;
    logic                        ce_out;

    modport master (
        output clk_enable,
        output input_bit,
        input  output_data,
        input  ce_out
    );

    modport slave (
        input  clk_enable,
        input  input_bit,
        output output_data,
        output ce_out
    );
endinterface

// File: rtl/cic_decimator.sv
// N-stage decimating CIC: 1-bit sigma-delta bitstream in, saturated signed PCM out at 1/R rate.
// Integrators run at the input rate; combs and the output register fire on the decimation strobe.
module cic_decimator #(
    parameter int STAGES     = 4,
    parameter int DECIM_LOG2 = 4,
    parameter int OUT_WIDTH  = 16
) (
    input  logic            clk,
    input  logic            reset,
    cic_decimator_if.slave  bus
);
    localparam int W         = STAGES * DECIM_LOG2 + 2;
    localparam int SHIFT_RAW = STAGES * DECIM_LOG2 - (OUT_WIDTH - 1);
    localparam int SHIFT     = (SHIFT_RAW > 0) ? SHIFT_RAW : 0;
    localparam int HEAD      = W - OUT_WIDTH + 1;

    localparam logic [DECIM_LOG2-1:0] PHASE_LAST = '1;
    localparam logic [OUT_WIDTH-1:0]  SAT_MAX    = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0]  SAT_MIN    = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    logic signed [W-1:0]          integ    [STAGES];
    logic signed [W-1:0]          dly      [STAGES];
    logic signed [W-1:0]          comb_tap [STAGES];
    logic signed [W-1:0]          comb_acc;
    logic signed [W-1:0]          comb_out;
    logic signed [W-1:0]          scaled;
    logic signed [W-1:0]          x;
    logic [HEAD-1:0]              head;
    logic [OUT_WIDTH-1:0]         sat;
    logic [DECIM_LOG2-1:0]        phase;
    logic                         dec_stb;

    assign x = bus.input_bit ? W'(1) : {W{1'b1}};

    // Each stage adds the pre-edge value of the previous one, so the chain is a register pipeline.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < STAGES; k++) begin
                integ[k] <= '0;
            end
        end else if (bus.clk_enable) begin
            integ[0] <= integ[0] + x;
            for (int k = 1; k < STAGES; k++) begin
                integ[k] <= integ[k] + integ[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase   <= '0;
            dec_stb <= 1'b0;
        end else begin
            dec_stb <= bus.clk_enable && (phase == PHASE_LAST);
            if (bus.clk_enable) begin
                phase <= phase + 1'b1;
            end
        end
    end

    // Comb chain evaluated in one pass; taps are the per-stage inputs that become the new delays.
    always_comb begin
        comb_acc = integ[STAGES-1];
        for (int k = 0; k < STAGES; k++) begin
            comb_tap[k] = comb_acc;
            comb_acc    = comb_acc - dly[k];
        end
        comb_out = comb_acc;
    end

    assign scaled = comb_out >>> SHIFT;
    assign head   = scaled[W-1:OUT_WIDTH-1];

    always_comb begin
        sat = scaled[OUT_WIDTH-1:0];
        if (head != '0 && head != '1) begin
            sat = scaled[W-1] ? SAT_MIN : SAT_MAX;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < STAGES; k++) begin
                dly[k] <= '0;
            end
            bus.output_data <= '0;
            bus.ce_out      <= 1'b0;
        end else begin
            bus.ce_out <= dec_stb;
            if (dec_stb) begin
                for (int k = 0; k < STAGES; k++) begin
                    dly[k] <= comb_tap[k];
                end
                bus.output_data <= sat;
            end
        end
    end
endmodule

// File: tb/tb_cic_decimator.sv
// Directed bench for cic_decimator: hand-computed CIC step responses, timing of ce_out, reset behaviour.
module tb_cic_decimator;
    localparam int R = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;

    cic_decimator_if #(.OUT_WIDTH(16)) bus ();

    cic_decimator #(
        .STAGES(4),
        .DECIM_LOG2(4),
        .OUT_WIDTH(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    int n_acc    = 0;

    logic [15:0] exp_q[$];
    int          exp_cyc_q[$];
    logic [15:0] obs_q[$];
    int          obs_cyc_q[$];

    always @(negedge clk) begin
        if (bus.ce_out) begin
            obs_q.push_back(bus.output_data);
            obs_cyc_q.push_back(cyc);
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // k-th output after reset (1-based) for a continuous constant or alternating input.
    function automatic int exp_value(input int mode, input int k);
        int v;
        case (mode)
            0: case (k) 1: v = 910;  2: v = 14340;  3: v = 30830;  default: v = 32767;  endcase
            1: case (k) 1: v = -910; 2: v = -14340; 3: v = -30830; default: v = -32768; endcase
            default: case (k) 1: v = 126; 2: v = 676; 3: v = 222; default: v = 0; endcase
        endcase
        return v;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            bus.clk_enable = 1'b0;
            bus.input_bit  = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic drive(input int n, input int mode, input int gap);
        logic b;
        for (int i = 0; i < n; i++) begin
            b = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : ((n_acc % 2) == 0);
            @(posedge clk); #1;
            bus.clk_enable = 1'b1;
            bus.input_bit  = b;
            n_acc++;
            if ((n_acc % R) == 0) begin
                exp_cyc_q.push_back(cyc + 2);
                exp_q.push_back(16'(exp_value(mode, n_acc / R)));
            end
            idle(gap);
        end
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        bus.clk_enable = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        n_acc = 0;
    endtask

    task automatic score(input string tag);
        int n;
        idle(4);
        check($sformatf("%s_count", tag), obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_cyc%0d", tag, i), obs_cyc_q[i], exp_cyc_q[i]);
            check($sformatf("%s_val%0d", tag, i), int'($signed(obs_q[i])), int'($signed(exp_q[i])));
        end
        obs_q.delete();
        obs_cyc_q.delete();
        exp_q.delete();
        exp_cyc_q.delete();
    endtask

    initial begin
        bus.clk_enable = 1'b0;
        bus.input_bit  = 1'b0;
        #2 reset = 1'b0;

        // Held in reset with random activity on the inputs.
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            bus.clk_enable = 1'($urandom_range(0, 1));
            bus.input_bit  = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("rst_data", bus.output_data, 0);
            check("rst_ce", bus.ce_out, 0);
        end
        check("rst_no_strobe", obs_q.size(), 0);
        obs_q.delete();
        obs_cyc_q.delete();
        @(posedge clk); #1;
        bus.clk_enable = 1'b0;
        reset = 1'b1;
        n_acc = 0;

        drive(200, 0, 0);
        score("ones");

        apply_reset();
        drive(200, 1, 0);
        score("zeros");

        apply_reset();
        drive(200, 2, 0);
        score("alt");

        apply_reset();
        drive(200, 0, 2);
        score("sparse");

        // Reset after the 10th input of the sixth frame.
        apply_reset();
        drive(90, 0, 0);
        @(posedge clk); #1;
        bus.clk_enable = 1'b0;
        reset = 1'b0;
        #1;
        check("mid_rst_data", bus.output_data, 0);
        check("mid_rst_ce", bus.ce_out, 0);
        repeat (2) begin
            @(negedge clk);
            check("mid_rst_hold_data", bus.output_data, 0);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        n_acc = 0;
        drive(80, 0, 0);
        score("mid_rst");

        // Reset lands while the decimation strobe is pending: that sample must never appear.
        apply_reset();
        drive(16, 0, 0);
        @(posedge clk); #1;
        bus.clk_enable = 1'b0;
        reset = 1'b0;
        void'(exp_q.pop_back());
        void'(exp_cyc_q.pop_back());
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        n_acc = 0;
        drive(32, 0, 0);
        score("pend_rst");

        // Integrators wrap many times over; output must stay pinned at full scale.
        apply_reset();
        drive(4096, 0, 0);
        score("long");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
